memory_port_arbiter: RTL and testbench
======================================

# memory_port_arbiter

Synchronous arbiter that shares the single memory port between the instruction-fetch requester and the data-cache requester. It issues the memory transaction for one owner at a time. It also drives the dual-rail phase codes `ph0` (instruction) and `ph1` (cache) that steer the memory output demux. It sequences the return-to-null handshake using the demux's `ack_to_mem`. It sits between the fetch unit, the cache controller, the memory and the memory output demux.

## Interface
Parameters:
- `ADDR_W`, 8: memory address width.
- `TIMEOUT`, 15: maximum cycles spent in ISSUE or WAIT_ACK before abort (≥2).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `instr_req` in 1: fetch read request (level).
- `instr_addr` in ADDR_W: fetch address.
- `instr_gnt` out 1: one-cycle pulse, fetch request accepted.
- `instr_done` out 1: one-cycle pulse, fetch transaction finished.
- `cache_req` in 1: cache request (level).
- `cache_we` in 1: 1 = write, 0 = read.
- `cache_addr` in ADDR_W: cache address.
- `cache_wdata` in 16: cache write word.
- `cache_gnt` out 1: one-cycle pulse, cache request accepted.
- `cache_done` out 1: one-cycle pulse, cache transaction finished.
- `mem_req` out 1: memory request, held until `mem_ack`.
- `mem_we` out 1: write strobe qualifier.
- `mem_addr` out ADDR_W: latched owner address.
- `mem_wdata` out 16: latched write word.
- `mem_ack` in 1: memory accepted request.
- `mem_rdata` in 16: memory output word. Non-null when bit15 or bit14 is set; null when `[15:14]`=00.
- `ack_to_mem` in 1: demux has latched the word.
- `ph0` out 2: instruction phase code. 10 = steer, 01 = idle.
- `ph1` out 2: cache phase code. Same encoding.
- `timeout_err` out 1: one-cycle pulse on abort.

## Operation
- States: IDLE, ISSUE, WAIT_ACK, RELEASE.
- IDLE:
  - Ignores requests in any cycle where a `*_done` is high.
  - Otherwise, if any request is present, picks a winner.
  - A single request wins outright. If both are present, the owner not served last wins.
  - After reset, `last_owner` = cache, so instruction wins the first tie.
  - Latches owner, address, `we` (forced 0 for instruction) and `wdata`. Goes to ISSUE.
- ISSUE:
  - `mem_req`=1 with `mem_addr`/`mem_we`/`mem_wdata` stable.
  - On `mem_ack`: write goes to RELEASE; read goes to WAIT_ACK.
- WAIT_ACK:
  - Owner's phase = 10; the other phase stays 01.
  - On `ack_to_mem`=1, go to RELEASE.
- RELEASE:
  - Both phases = 01.
  - When `ack_to_mem`=0 and `mem_rdata[15:14]`=00, go to IDLE, pulse the owner's `*_done` and set `last_owner`.
- Timeout:
  - Counter is cleared on entry to ISSUE/WAIT_ACK and increments each cycle there.
  - If it reaches TIMEOUT−1 without the exit condition, go directly to IDLE.
  - On abort: pulse `timeout_err` and the owner's `*_done`, drop `mem_req`, phases = 01, update `last_owner`.
- Simultaneous exit condition and timeout: the exit condition wins, with no error.
- `ph0` and `ph1` are never 00 or 11, and never both 10.
- Requests that arrive while busy are held (level) and arbitrated in the next eligible IDLE cycle.

## Timing
- All outputs are registered.
- Reset values: state IDLE, `ph0`=`ph1`=01, `mem_req`/`mem_we`=0, `mem_addr`/`mem_wdata`=0, all gnt/done/err=0, counter 0, `last_owner`=cache.
- Request sampled in IDLE at edge N:
  - cycle N+1: ISSUE with `*_gnt`=1 and `mem_req`=1. Minimum grant latency is 1 cycle.
  - `mem_ack` sampled at edge M: cycle M+1 has `mem_req`=0 and phase=10 (read), or RELEASE (write).
  - `ack_to_mem` sampled high: next cycle phase=01.
  - Null plus ack low sampled: next cycle is IDLE with `done`=1.
- Minimum read transaction: gnt to done is 4 cycles. Minimum write: 3 cycles.
- Requester must drop `req` on the edge after it sees `done`, or it re-requests.
- Reset asserted mid-transaction: the next edge forces reset values; the in-flight transaction is dropped with no done pulse.

## Structure
- Shared package `mem_arb_pkg`:
  - state enum.
  - owner enum (OWN_INSTR, OWN_CACHE).
  - constants PH_ON=2'b10, PH_OFF=2'b01.
  - function `is_null(word)` on bits [15:14].
- Sub-module `rr_picker2`: combinational two-way round-robin pick from (req0, req1, last_owner) → (valid, winner).

## Test plan
- Reset then `instr_req` with addr 0x12:
  - `instr_gnt` one cycle later, `mem_addr`=0x12, `ph0`=10 after `mem_ack`.
  - `rdata`=0x8ABC, ack high then low/null → `instr_done`, 4 cycles minimum.
- Both requests high continuously for 4 transactions: grants alternate instr, cache, instr, cache.
- Cache write of 0x4321 to 0x05:
  - `mem_we`=1 and `mem_wdata`=0x4321 until `mem_ack`.
  - Phases stay 01 throughout; `cache_done` follows.
- `mem_ack` never asserted, TIMEOUT=15:
  - `timeout_err` and `instr_done` 15 cycles after entering ISSUE; state back to IDLE.
  - `mem_ack` asserted on the last counted cycle → no error.
- `rst` asserted during WAIT_ACK: next cycle `ph0`=01, `mem_req`=0, no done; the next tie grants instruction.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory port arbiter: FSM states, owner
// identity, dual-rail phase codes and the null-word test.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_RELEASE
    } state_t;

    typedef enum logic {
        OWN_INSTR = 1'b0,
        OWN_CACHE = 1'b1
    } owner_t;

    localparam logic [1:0] PH_ON  = 2'b10;
    localparam logic [1:0] PH_OFF = 2'b01;

    // A dual-rail word is null (spacer) when neither rail of the top pair is set.
    function automatic logic is_null(input logic [15:0] word);
        return word[15:14] == 2'b00;
    endfunction

endpackage

// File: rtl/rr_picker2.sv
// Two-way round-robin pick: a lone request wins outright, a tie goes to the
// requester that was not served last. Index 0 = instruction, 1 = cache.
module rr_picker2 (
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_owner_i,
    output logic valid_o,
    output logic winner_o
);

    assign valid_o  = req0_i | req1_i;
    assign winner_o = (req0_i & req1_i) ? ~last_owner_i : req1_i;

endmodule

// File: rtl/memory_port_arbiter.sv
// Shares the single memory port between instruction fetch and the data cache,
// steers the output demux with dual-rail phase codes and runs return-to-null.
module memory_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_req,
    input  logic [ADDR_W-1:0] instr_addr,
    output logic              instr_gnt,
    output logic              instr_done,
    input  logic              cache_req,
    input  logic              cache_we,
    input  logic [ADDR_W-1:0] cache_addr,
    input  logic [15:0]       cache_wdata,
    output logic              cache_gnt,
    output logic              cache_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata,
    input  logic              ack_to_mem,
    output logic [1:0]        ph0,
    output logic [1:0]        ph1,
    output logic              timeout_err
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    owner_t            last_q, last_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              igrant_q, igrant_d, cgrant_q, cgrant_d;
    logic              idone_q, idone_d, cdone_q, cdone_d;
    logic              err_q, err_d;
    logic              mreq_q, mreq_d, mwe_q, mwe_d;
    logic [1:0]        ph0_q, ph0_d, ph1_q, ph1_d;

    logic pick_valid, pick_winner;
    logic end_txn, end_err, timed_out;

    rr_picker2 u_pick (
        .req0_i       (instr_req),
        .req1_i       (cache_req),
        .last_owner_i (last_q),
        .valid_o      (pick_valid),
        .winner_o     (pick_winner)
    );

    assign timed_out = (cnt_q == CNT_LAST);

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        cnt_d    = cnt_q + 1'b1;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        igrant_d = 1'b0;
        cgrant_d = 1'b0;
        end_txn  = 1'b0;
        end_err  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                // The done cycle is a dead cycle so the finished requester can drop req.
                if (!(idone_q | cdone_q) && pick_valid) begin
                    owner_d  = owner_t'(pick_winner);
                    addr_d   = pick_winner ? cache_addr : instr_addr;
                    we_d     = pick_winner & cache_we;
                    wdata_d  = pick_winner ? cache_wdata : 16'h0000;
                    igrant_d = ~pick_winner;
                    cgrant_d = pick_winner;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mem_ack) begin
                    cnt_d   = '0;
                    state_d = we_q ? ST_RELEASE : ST_WAIT_ACK;
                end else if (timed_out) begin
                    end_txn = 1'b1;
                    end_err = 1'b1;
                end
            end
            ST_WAIT_ACK: begin
                if (ack_to_mem) begin
                    cnt_d   = '0;
                    state_d = ST_RELEASE;
                end else if (timed_out) begin
                    end_txn = 1'b1;
                    end_err = 1'b1;
                end
            end
            default: begin
                cnt_d = '0;
                if (!ack_to_mem && is_null(mem_rdata)) end_txn = 1'b1;
            end
        endcase

        if (end_txn) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            last_d  = owner_q;
        end

        idone_d = end_txn & (owner_q == OWN_INSTR);
        cdone_d = end_txn & (owner_q == OWN_CACHE);
        err_d   = end_err;
        mreq_d  = (state_d == ST_ISSUE);
        mwe_d   = (state_d == ST_ISSUE) & we_d;
        ph0_d   = (state_d == ST_WAIT_ACK && owner_d == OWN_INSTR) ? PH_ON : PH_OFF;
        ph1_d   = (state_d == ST_WAIT_ACK && owner_d == OWN_CACHE) ? PH_ON : PH_OFF;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            owner_q  <= OWN_INSTR;
            last_q   <= OWN_CACHE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            igrant_q <= 1'b0;
            cgrant_q <= 1'b0;
            idone_q  <= 1'b0;
            cdone_q  <= 1'b0;
            err_q    <= 1'b0;
            mreq_q   <= 1'b0;
            mwe_q    <= 1'b0;
            ph0_q    <= PH_OFF;
            ph1_q    <= PH_OFF;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            igrant_q <= igrant_d;
            cgrant_q <= cgrant_d;
            idone_q  <= idone_d;
            cdone_q  <= cdone_d;
            err_q    <= err_d;
            mreq_q   <= mreq_d;
            mwe_q    <= mwe_d;
            ph0_q    <= ph0_d;
            ph1_q    <= ph1_d;
        end
    end

    assign instr_gnt   = igrant_q;
    assign cache_gnt   = cgrant_q;
    assign instr_done  = idone_q;
    assign cache_done  = cdone_q;
    assign timeout_err = err_q;
    assign mem_req     = mreq_q;
    assign mem_we      = mwe_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign ph0         = ph0_q;
    assign ph1         = ph1_q;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Scoreboard bench for memory_port_arbiter: expected grants are queued when a
// request is driven and matched against grant/done pulses by a monitor.
module tb_memory_port_arbiter;

    typedef struct {
        logic        owner;
        logic [7:0]  addr;
        logic        we;
        logic [15:0] wdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_req = 1'b0;
    logic [7:0]  instr_addr = '0;
    logic        instr_gnt, instr_done;
    logic        cache_req = 1'b0;
    logic        cache_we = 1'b0;
    logic [7:0]  cache_addr = '0;
    logic [15:0] cache_wdata = '0;
    logic        cache_gnt, cache_done;
    logic        mem_req, mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic        ack_to_mem = 1'b0;
    logic [1:0]  ph0, ph1;
    logic        timeout_err;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    logic pend_q[$];
    exp_t mon_e;
    logic mon_o;

    memory_port_arbiter #(.ADDR_W(8), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .instr_req(instr_req), .instr_addr(instr_addr),
        .instr_gnt(instr_gnt), .instr_done(instr_done),
        .cache_req(cache_req), .cache_we(cache_we), .cache_addr(cache_addr),
        .cache_wdata(cache_wdata), .cache_gnt(cache_gnt), .cache_done(cache_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ack_to_mem(ack_to_mem), .ph0(ph0), .ph1(ph1), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit sig_hit(input int which);
        case (which)
            0:       return instr_gnt | cache_gnt;
            1:       return mem_req;
            2:       return instr_done | cache_done;
            default: return timeout_err;
        endcase
    endfunction

    task automatic wait_sig(input int which, input int max, input string tag, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (sig_hit(which)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk(tag, 0, 1);
    endtask

    // Called in an ISSUE cycle: accept, then (for reads) deliver a word and return to null.
    task automatic serve(input bit own, input bit wr);
        bit ok;
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("srv_req_drop", mem_req, 0);
        chk("srv_no_err", timeout_err, 0);
        if (!wr) begin
            chk("srv_ph_on", own ? ph1 : ph0, 2'b10);
            chk("srv_ph_other", own ? ph0 : ph1, 2'b01);
            mem_rdata  = 16'h8ABC;
            ack_to_mem = 1'b1;
            @(negedge clk);
            chk("srv_ph_null", {ph0, ph1}, 4'b0101);
            ack_to_mem = 1'b0;
            mem_rdata  = 16'h0000;
        end else begin
            chk("srv_wr_ph", {ph0, ph1}, 4'b0101);
        end
        wait_sig(2, 6, "srv_done_timeout", ok);
    endtask

    // Monitor: legal phase codes every cycle; grants and dones against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            chk("ph_legal", ((ph0 == 2'b01 || ph0 == 2'b10) && (ph1 == 2'b01 || ph1 == 2'b10)
                             && !(ph0 == 2'b10 && ph1 == 2'b10)), 1);
            if (instr_gnt || cache_gnt) begin
                if (exp_q.size() == 0) begin
                    chk("gnt_unexpected", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("gnt_single", instr_gnt ^ cache_gnt, 1);
                    chk("gnt_owner", cache_gnt, mon_e.owner);
                    chk("gnt_addr", mem_addr, mon_e.addr);
                    chk("gnt_we", mem_we, mon_e.we);
                    chk("gnt_req", mem_req, 1);
                    if (mon_e.we) chk("gnt_wdata", mem_wdata, mon_e.wdata);
                    pend_q.push_back(mon_e.owner);
                end
            end
            if (instr_done || cache_done) begin
                if (pend_q.size() == 0) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    mon_o = pend_q.pop_front();
                    chk("done_single", instr_done ^ cache_done, 1);
                    chk("done_owner", cache_done, mon_o);
                end
            end
        end
    end

    initial begin
        bit ok;
        int g;

        repeat (2) @(negedge clk);
        chk("rst_ph", {ph0, ph1}, 4'b0101);
        chk("rst_req", {mem_req, mem_we}, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_pulses", {instr_gnt, cache_gnt, instr_done, cache_done, timeout_err}, 0);

        // Single instruction read at 0x12, minimum path.
        rst = 1'b0;
        instr_req = 1'b1; instr_addr = 8'h12;
        exp_q.push_back('{1'b0, 8'h12, 1'b0, 16'h0000});
        wait_sig(0, 5, "t1_gnt_timeout", ok);
        g = cyc;
        chk("t1_gnt", instr_gnt, 1);
        chk("t1_addr", mem_addr, 8'h12);
        serve(1'b0, 1'b0);
        chk("t1_done", instr_done, 1);
        chk("t1_latency", cyc - g, 3);  // gnt cycle through done cycle inclusive = 4
        instr_req = 1'b0;

        // Both requests held: last served was instruction, so cache wins first.
        instr_req = 1'b1; instr_addr = 8'h33;
        cache_req = 1'b1; cache_addr = 8'h44; cache_we = 1'b0;
        exp_q.push_back('{1'b1, 8'h44, 1'b0, 16'h0000});
        exp_q.push_back('{1'b0, 8'h33, 1'b0, 16'h0000});
        exp_q.push_back('{1'b1, 8'h44, 1'b0, 16'h0000});
        exp_q.push_back('{1'b0, 8'h33, 1'b0, 16'h0000});
        for (int t = 0; t < 4; t++) begin
            wait_sig(0, 5, "t2_gnt_timeout", ok);
            chk("t2_alt", cache_gnt, (t % 2 == 0));
            serve(t % 2 == 0, 1'b0);
        end
        instr_req = 1'b0; cache_req = 1'b0;

        // Cache write 0x4321 -> 0x05, ack withheld for two cycles.
        cache_req = 1'b1; cache_we = 1'b1; cache_addr = 8'h05; cache_wdata = 16'h4321;
        exp_q.push_back('{1'b1, 8'h05, 1'b1, 16'h4321});
        wait_sig(0, 5, "t3_gnt_timeout", ok);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t3_hold_req", {mem_req, mem_we}, 2'b11);
            chk("t3_hold_wdata", mem_wdata, 16'h4321);
            chk("t3_hold_ph", {ph0, ph1}, 4'b0101);
        end
        serve(1'b1, 1'b1);
        chk("t3_done", cache_done, 1);
        cache_req = 1'b0; cache_we = 1'b0;

        // No mem_ack: abort 15 cycles after entering ISSUE.
        instr_req = 1'b1; instr_addr = 8'h77;
        exp_q.push_back('{1'b0, 8'h77, 1'b0, 16'h0000});
        wait_sig(0, 5, "t4_gnt_timeout", ok);
        g = cyc;
        instr_req = 1'b0;
        wait_sig(3, 30, "t4_err_missing", ok);
        chk("t4_latency", cyc - g, 15);
        chk("t4_done", instr_done, 1);
        chk("t4_drop", mem_req, 0);
        chk("t4_ph", ph0, 2'b01);

        // mem_ack on the last counted cycle: exit wins, no error.
        instr_req = 1'b1; instr_addr = 8'h78;
        exp_q.push_back('{1'b0, 8'h78, 1'b0, 16'h0000});
        wait_sig(0, 5, "t5_gnt_timeout", ok);
        instr_req = 1'b0;
        repeat (14) @(negedge clk);
        chk("t5_still_issue", mem_req, 1);
        serve(1'b0, 1'b0);
        chk("t5_done", instr_done, 1);

        // Reset during WAIT_ACK; last owner was instruction, reset makes it lose no more.
        instr_req = 1'b1; instr_addr = 8'h55;
        exp_q.push_back('{1'b0, 8'h55, 1'b0, 16'h0000});
        wait_sig(0, 5, "t6_gnt_timeout", ok);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("t6_wait_ph", ph0, 2'b10);
        rst = 1'b1;
        cache_req = 1'b1; cache_addr = 8'h66;
        @(negedge clk);
        chk("t6_rst_ph", ph0, 2'b01);
        chk("t6_rst_req", mem_req, 0);
        chk("t6_rst_nodone", instr_done, 0);
        pend_q.delete();
        rst = 1'b0;
        exp_q.push_back('{1'b0, 8'h55, 1'b0, 16'h0000});
        wait_sig(0, 5, "t6_gnt_timeout2", ok);
        chk("t6_tie_instr", instr_gnt, 1);
        instr_req = 1'b0; cache_req = 1'b0;
        serve(1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk("sb_exp_empty", exp_q.size(), 0);
        chk("sb_pend_empty", pend_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "bench did not finish");
    end

endmodule
